// File: rtl/fma16_arb.sv
// fma16_arb: two-requester round-robin/fixed-priority sequencer around one shared fma16 datapath.
// Optional feature: define FMA16_ARB_STICKY_EN to build the sticky exception-flag register.

module fma16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  // Exact fixed-point sum with LSB weight 2^-48 covers every product and addend bit.
  localparam int W = 82;
  localparam logic [W-1:0] ONE_W = W'(1);

  function automatic logic [10:0] sig(input logic [15:0] v);
    return {|v[14:10], v[9:0]};
  endfunction
  function automatic logic [4:0] bexp(input logic [15:0] v);
    return (v[14:10] == 5'd0) ? 5'd1 : v[14:10];
  endfunction
  function automatic logic is_inf(input logic [15:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] == 10'd0);
  endfunction
  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
  endfunction
  function automatic logic is_zero(input logic [15:0] v);
    return v[14:0] == 15'd0;
  endfunction

  logic [15:0]  yv, zv;
  logic [21:0]  prod;
  logic [6:0]   pshift, zshift, p, lsb, expo_f;
  logic [W-1:0] pmag, zmag, smag, lowmask;
  logic         ps, zs, rs, rnd, stk, inc, inv, ovf, to_inf;
  logic [10:0]  mant;
  logic [31:0]  bits;

  assign yv = mul ? y : 16'h3c00;
  assign zv = add ? z : 16'h0000;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can leave one
    // holding its old value and infer a latch.
    prod    = '0;
    pshift  = '0;
    zshift  = '0;
    pmag    = '0;
    zmag    = '0;
    smag    = '0;
    lowmask = '0;
    p       = '0;
    lsb     = 7'd24;
    expo_f  = '0;
    mant    = '0;
    bits    = '0;
    rnd     = 1'b0;
    stk     = 1'b0;
    inc     = 1'b0;
    ovf     = 1'b0;
    to_inf  = 1'b0;
    rs      = 1'b0;
    result  = '0;
    flags   = '0;

    ps  = x[15] ^ yv[15] ^ negp;
    zs  = zv[15] ^ negz;
    inv = (is_nan(x) && !x[9]) || (is_nan(yv) && !yv[9]) || (is_nan(zv) && !zv[9])
       || (is_inf(x) && is_zero(yv)) || (is_zero(x) && is_inf(yv))
       || ((is_inf(x) || is_inf(yv)) && is_inf(zv) && (ps != zs));

    prod   = {11'd0, sig(x)} * {11'd0, sig(yv)};
    pshift = {2'd0, bexp(x)} + {2'd0, bexp(yv)} - 7'd2;
    zshift = {2'd0, bexp(zv)} + 7'd23;
    pmag   = {{(W-22){1'b0}}, prod} << pshift;
    zmag   = {{(W-11){1'b0}}, sig(zv)} << zshift;

    if (ps == zs) begin
      smag = pmag + zmag;
      rs   = ps;
    end else if (pmag >= zmag) begin
      smag = pmag - zmag;
      rs   = ps;
    end else begin
      smag = zmag - pmag;
      rs   = zs;
    end

    for (int i = 0; i < W; i++) begin
      if (smag[i]) p = 7'(i);
    end

    // Results below the normal range keep a fixed 2^-24 LSB (subnormal encoding).
    lsb     = (p >= 7'd34) ? p - 7'd10 : 7'd24;
    expo_f  = (p >= 7'd34) ? p - 7'd34 : 7'd0;
    mant    = 11'(smag >> lsb);
    rnd     = smag[lsb - 7'd1];
    lowmask = (ONE_W << (lsb - 7'd1)) - ONE_W;
    stk     = |(smag & lowmask);

    unique case (roundmode)
      2'b01:   inc = rnd && (stk || mant[0]);
      2'b10:   inc = rs && (rnd || stk);
      2'b11:   inc = !rs && (rnd || stk);
      default: inc = 1'b0;
    endcase

    // Hidden bit carries into the exponent field, so one add handles renormalisation.
    bits   = {15'd0, expo_f, 10'd0} + {21'd0, mant} + {31'd0, inc};
    ovf    = bits >= 32'h0000_7c00;
    to_inf = (roundmode == 2'b01) || (roundmode == 2'b10 && rs) || (roundmode == 2'b11 && !rs);

    if (is_nan(x) || is_nan(yv) || is_nan(zv) || inv) begin
      result = 16'h7e00;
      flags  = {inv, 3'b000};
    end else if (is_inf(x) || is_inf(yv)) begin
      result = {ps, 15'h7c00};
    end else if (is_inf(zv)) begin
      result = {zs, 15'h7c00};
    end else if (smag == '0) begin
      result = {(ps == zs) ? ps : (roundmode == 2'b10), 15'd0};
    end else if (ovf) begin
      result = {rs, to_inf ? 15'h7c00 : 15'h7bff};
      flags  = 4'b0101;
    end else begin
      result = {rs, bits[14:0]};
      flags  = {1'b0, 1'b0, (p < 7'd34) && (rnd || stk), rnd || stk};
    end
  end
endmodule

module fma16_arb #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req0_z,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [15:0] req1_z,
  input  logic [5:0]  req0_ctrl,
  input  logic [5:0]  req1_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  flags_sticky,
  input  logic        flags_clr
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_grant, grant, accept, id_q;
  logic [15:0] x_q, y_q, z_q, fma_result;
  logic [5:0]  ctrl_q;
  logic [3:0]  fma_flags;

  always_comb begin
    grant = 1'b0;
    unique case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = PRIO_FIXED ? 1'b0 : ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready[grant] = |req_valid;
        accept           = |req_valid;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) last_grant <= grant;
    end
  end

  // NOTE: operand registers are deliberately not reset; they are only read in EXEC,
  // which is reachable only through a load.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q    <= grant ? req1_x : req0_x;
      y_q    <= grant ? req1_y : req0_y;
      z_q    <= grant ? req1_z : req0_z;
      ctrl_q <= grant ? req1_ctrl : req0_ctrl;
      id_q   <= grant;
    end
  end

  fma16 u_fma16 (
    .x         (x_q),
    .y         (y_q),
    .z         (z_q),
    .mul       (ctrl_q[3]),
    .add       (ctrl_q[2]),
    .negp      (ctrl_q[1]),
    .negz      (ctrl_q[0]),
    .roundmode (ctrl_q[5:4]),
    .result    (fma_result),
    .flags     (fma_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else if (state == EXEC) begin
      rsp_id     <= id_q;
      rsp_result <= fma_result;
      rsp_flags  <= fma_flags;
    end
  end

`ifdef FMA16_ARB_STICKY_EN
  logic [3:0] sticky_q;

  // A clear coincident with a capture keeps only the new operation's flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= '0;
    end else if (state == EXEC) begin
      sticky_q <= (flags_clr ? 4'b0000 : sticky_q) | fma_flags;
    end else if (flags_clr) begin
      sticky_q <= '0;
    end
  end

  assign flags_sticky = sticky_q;
`else
  logic unused_flags_clr;

  assign unused_flags_clr = flags_clr;
  assign flags_sticky     = 4'b0000;
`endif
endmodule
